// File: rtl/expipe_pkg.sv
// expipe_pkg: execution-pipeline load/store types, exception codes and load result buffer entry.
package expipe_pkg;
  import len5_pkg::*;
  typedef enum logic [2:0] {
    LS_BYTE,
    LS_BYTE_U,
    LS_HALFWORD,
    LS_HALFWORD_U,
    LS_WORD,
    LS_WORD_U,
    LS_DOUBLEWORD
  } ldst_type_t;
  localparam int E_LD_ADDR_MISALIGNED = 4;
  localparam int E_LD_ACCESS_FAULT = 5;
  localparam int LRB_ROB_IDX_LEN = 4;
  typedef struct packed {
    ldst_type_t ld_type;
    logic [2:0] byte_off;
    logic [XLEN-1:0] line;
    logic [LRB_ROB_IDX_LEN-1:0] rob_idx;
    logic except;
  } lrb_entry_t;
endpackage

// File: rtl/len5_pkg.sv
// len5_pkg: core-wide datapath width.
package len5_pkg;
  localparam int XLEN = 64;
endpackage

// File: rtl/byte_selector.sv
// byte_selector: extracts the addressed byte/half/word from a doubleword and extends it to XLEN.
module byte_selector
  import len5_pkg::*;
  import expipe_pkg::*;
(
  input  ldst_type_t      type_i,
  input  logic [2:0]      byte_off_i,
  input  logic [XLEN-1:0] line_i,
  output logic [XLEN-1:0] data_o
);
  logic [31:0] word;
  logic [15:0] half;
  logic [7:0] byte_v;
  assign word = byte_off_i[2] ? line_i[63:32] : line_i[31:0];
  assign half = byte_off_i[1] ? word[31:16] : word[15:0];
  assign byte_v = byte_off_i[0] ? half[15:8] : half[7:0];
  always_comb begin
    data_o = line_i;
    case (type_i)
      LS_BYTE:       data_o = {{56{byte_v[7]}}, byte_v};
      LS_BYTE_U:     data_o = {56'd0, byte_v};
      LS_HALFWORD:   data_o = {{48{half[15]}}, half};
      LS_HALFWORD_U: data_o = {48'd0, half};
      LS_WORD:       data_o = {{32{word[31]}}, word};
      LS_WORD_U:     data_o = {32'd0, word};
      default:       data_o = line_i;
    endcase
  end
endmodule

// File: rtl/load_result_buffer.sv
// load_result_buffer: in-order FIFO of raw load responses; extracts, aligns and checks the head for the CDB.
module load_result_buffer
  import len5_pkg::*;
  import expipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_IDX_LEN = 4,
  parameter int EXCEPT_LEN = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   mem_valid_i,
  output logic                   mem_ready_o,
  input  ldst_type_t             mem_type_i,
  input  logic [2:0]             mem_byte_off_i,
  input  logic [XLEN-1:0]        mem_line_i,
  input  logic [ROB_IDX_LEN-1:0] mem_rob_idx_i,
  input  logic                   mem_except_i,
  output logic                   cdb_valid_o,
  input  logic                   cdb_ready_i,
  output logic [ROB_IDX_LEN-1:0] cdb_rob_idx_o,
  output logic [XLEN-1:0]        cdb_data_o,
  output logic                   cdb_except_raised_o,
  output logic [EXCEPT_LEN-1:0]  cdb_except_code_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  lrb_entry_t entries [DEPTH];
  lrb_entry_t head_e;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic push, pop, misaligned;
  logic [XLEN-1:0] sel_data;
  assign mem_ready_o = count != FULL;
  assign cdb_valid_o = count != '0;
  assign push = mem_valid_i && mem_ready_o && !flush_i;
  assign pop = cdb_valid_o && cdb_ready_i && !flush_i;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush_i) begin
      head <= tail;
      count <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Entry payload needs no reset: it is only observed while count says it is live.
  always_ff @(posedge clk_i) begin
    if (push) entries[tail] <= '{ld_type: mem_type_i, byte_off: mem_byte_off_i, line: mem_line_i,
                                 rob_idx: LRB_ROB_IDX_LEN'(mem_rob_idx_i), except: mem_except_i};
  end
  assign head_e = entries[head];
  byte_selector u_byte_selector (
    .type_i    (head_e.ld_type),
    .byte_off_i(head_e.byte_off),
    .line_i    (head_e.line),
    .data_o    (sel_data)
  );
  always_comb begin
    misaligned = 1'b0;
    case (head_e.ld_type)
      LS_HALFWORD, LS_HALFWORD_U: misaligned = head_e.byte_off[0];
      LS_WORD, LS_WORD_U:         misaligned = head_e.byte_off[1:0] != 2'd0;
      LS_DOUBLEWORD:              misaligned = head_e.byte_off != 3'd0;
      default:                    misaligned = 1'b0;
    endcase
  end
  assign cdb_rob_idx_o = ROB_IDX_LEN'(head_e.rob_idx);
  assign cdb_except_raised_o = head_e.except || misaligned;
  assign cdb_except_code_o = head_e.except ? EXCEPT_LEN'(E_LD_ACCESS_FAULT)
                           : misaligned ? EXCEPT_LEN'(E_LD_ADDR_MISALIGNED) : '0;
  assign cdb_data_o = cdb_except_raised_o ? '0 : sel_data;
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && count == FULL));
  assert property (@(posedge clk_i) disable iff (!rst_n_i) !(pop && count == '0));
`endif
endmodule

// File: tb/tb_load_result_buffer.sv
// tb_load_result_buffer: scoreboard bench for load_result_buffer.
module tb_load_result_buffer;
  import len5_pkg::*;
  import expipe_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [63:0] LINE = 64'h8877665544332211;
  logic clk_i = 0, rst_n_i = 0, flush_i = 0, mem_valid_i = 0, mem_except_i = 0, cdb_ready_i = 0;
  logic mem_ready_o, cdb_valid_o, cdb_except_raised_o;
  ldst_type_t mem_type_i = LS_BYTE;
  logic [2:0] mem_byte_off_i = 0;
  logic [63:0] mem_line_i = 0, cdb_data_o;
  logic [3:0] mem_rob_idx_i = 0, cdb_rob_idx_o, cdb_except_code_o;
  typedef struct packed {
    logic [3:0] rob;
    logic [63:0] data;
    logic raised;
    logic [3:0] code;
  } exp_t;
  exp_t sb[$];
  int mcount = 0, nvec = 0, nerr = 0;

  load_result_buffer #(.DEPTH(DEPTH), .ROB_IDX_LEN(4), .EXCEPT_LEN(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .mem_valid_i(mem_valid_i),
    .mem_ready_o(mem_ready_o), .mem_type_i(mem_type_i), .mem_byte_off_i(mem_byte_off_i),
    .mem_line_i(mem_line_i), .mem_rob_idx_i(mem_rob_idx_i), .mem_except_i(mem_except_i),
    .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_rob_idx_o(cdb_rob_idx_o),
    .cdb_data_o(cdb_data_o), .cdb_except_raised_o(cdb_except_raised_o),
    .cdb_except_code_o(cdb_except_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Shift-and-mask reference, independent of the mux tree in the design.
  function automatic exp_t model(ldst_type_t t, logic [2:0] off, logic [63:0] line, logic [3:0] rob, logic exc);
    exp_t e;
    int sz;
    logic sgn;
    logic [63:0] sh, mask, v;
    sz = (t inside {LS_BYTE, LS_BYTE_U}) ? 1 : (t inside {LS_HALFWORD, LS_HALFWORD_U}) ? 2
       : (t inside {LS_WORD, LS_WORD_U}) ? 4 : 8;
    sgn = t inside {LS_BYTE, LS_HALFWORD, LS_WORD};
    sh = line >> (8 * int'(off));
    if (sz == 8) v = line;
    else begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = sh & mask;
      if (sgn && sh[8*sz-1]) v = v | ~mask;
    end
    e.rob = rob;
    e.raised = exc || (int'(off) % sz != 0);
    e.code = exc ? 4'd5 : e.raised ? 4'd4 : 4'd0;
    e.data = e.raised ? 64'd0 : v;
    return e;
  endfunction

  task automatic cycle(input logic v, input ldst_type_t t, input logic [2:0] off, input logic [63:0] line,
                       input logic [3:0] rob, input logic exc, input logic rdy, input logic fl);
    bit push, pop;
    exp_t e;
    mem_valid_i = v; mem_type_i = t; mem_byte_off_i = off; mem_line_i = line;
    mem_rob_idx_i = rob; mem_except_i = exc; cdb_ready_i = rdy; flush_i = fl;
    @(negedge clk_i);
    push = v && mcount != DEPTH && !fl;
    pop = mcount != 0 && rdy && !fl;
    chk("cdb_valid", 64'(cdb_valid_o), 64'(mcount != 0));
    chk("mem_ready", 64'(mem_ready_o), 64'(mcount != DEPTH));
    if (mcount != 0 && sb.size() > 0) begin
      chk("head_rob", 64'(cdb_rob_idx_o), 64'(sb[0].rob));
      if (pop) begin
        e = sb.pop_front();
        chk("data", cdb_data_o, e.data);
        chk("exc_raised", 64'(cdb_except_raised_o), 64'(e.raised));
        chk("exc_code", 64'(cdb_except_code_o), 64'(e.code));
      end
    end
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (push) sb.push_back(model(t, off, line, rob, exc));
      mcount += int'(push) - int'(pop);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, LS_BYTE, 3'd0, 64'd0, 4'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_reset();
    mem_valid_i = 0; flush_i = 0; cdb_ready_i = 0;
    #2 rst_n_i = 0;
    #1;
    chk("async_rst_valid", 64'(cdb_valid_o), 64'd0);
    chk("async_rst_ready", 64'(mem_ready_o), 64'd1);
    sb.delete();
    mcount = 0;
    @(posedge clk_i);
    #1 rst_n_i = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(cdb_valid_o), 64'd0);
    chk("rst_ready", 64'(mem_ready_o), 64'd1);
    rst_n_i = 1;
    idle(1);
    cycle(1, LS_BYTE, 3'd7, LINE, 4'd1, 0, 1, 0);
    cycle(1, LS_BYTE_U, 3'd7, LINE, 4'd2, 0, 1, 0);
    cycle(1, LS_HALFWORD, 3'd6, LINE, 4'd3, 0, 1, 0);
    cycle(1, LS_WORD, 3'd4, LINE, 4'd4, 0, 1, 0);
    cycle(1, LS_WORD_U, 3'd0, LINE, 4'd5, 0, 1, 0);
    cycle(1, LS_DOUBLEWORD, 3'd0, LINE, 4'd6, 0, 1, 0);
    idle(1);
    cycle(1, LS_WORD, 3'd2, LINE, 4'd3, 0, 1, 0);
    idle(1);
    cycle(1, LS_WORD, 3'd2, LINE, 4'd3, 1, 1, 0);
    cycle(1, LS_HALFWORD_U, 3'd1, LINE, 4'd7, 0, 1, 0);
    cycle(1, LS_DOUBLEWORD, 3'd4, LINE, 4'd8, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 4; i++) cycle(1, LS_WORD_U, 3'd4, LINE, 4'(i), 0, 0, 0);
    cycle(1, LS_BYTE, 3'd0, LINE, 4'd9, 0, 0, 0);
    repeat (10) idle(0);
    repeat (5) idle(1);
    for (int i = 0; i < 12; i++)
      cycle(1, ldst_type_t'($urandom_range(0, 6)), 3'($urandom_range(0, 7)),
            {$urandom, $urandom}, 4'(i), 1'($urandom_range(0, 1)), 1, 0);
    repeat (2) idle(1);
    for (int i = 0; i < 3; i++) cycle(1, LS_BYTE_U, 3'(i), LINE, 4'(10 + i), 0, 0, 0);
    cycle(1, LS_BYTE, 3'd5, LINE, 4'd15, 0, 1, 1);
    idle(1);
    cycle(1, LS_HALFWORD, 3'd2, LINE, 4'd14, 0, 1, 0);
    repeat (2) idle(1);
    for (int i = 0; i < 2; i++) cycle(1, LS_WORD, 3'd0, LINE, 4'(i + 1), 0, 0, 0);
    async_reset();
    cycle(1, LS_BYTE, 3'd1, LINE, 4'd12, 0, 1, 0);
    repeat (3) idle(1);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/load_result_buffer.md
Name: load_result_buffer

Overview:
- In-order FIFO between the cache access/forwarding stage and the CDB arbiter.
- Captures raw 64-bit load responses: line, byte offset, load type, ROB index and bus-error flag.
- At the head entry it extracts and sign/zero-extends the addressed data and checks alignment.
- Presents each result to the CDB with a valid/ready handshake; absorbs CDB back-pressure so the cache stage never stalls on a single lost grant.

Parameters:
- DEPTH, 4, number of buffered results; power of two, >= 2.
- ROB_IDX_LEN, 4, width of the ROB index tag.
- EXCEPT_LEN, 4, width of the exception code.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush (mispredict/exception)
- mem_valid_i  in  1  load response valid
- mem_ready_o  out  1  buffer can accept a response
- mem_type_i  in  ldst_type_t  load type
- mem_byte_off_i  in  3  byte offset within the doubleword
- mem_line_i  in  XLEN  raw doubleword from cache/forwarding
- mem_rob_idx_i  in  ROB_IDX_LEN  destination ROB entry
- mem_except_i  in  1  bus/access error on this response
- cdb_valid_o  out  1  head result valid
- cdb_ready_i  in  1  CDB grant
- cdb_rob_idx_o  out  ROB_IDX_LEN  ROB index of head
- cdb_data_o  out  XLEN  extracted, extended load data
- cdb_except_raised_o  out  1  head carries an exception
- cdb_except_code_o  out  EXCEPT_LEN  exception cause

Behaviour:
- Storage and pointers:
  - Circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping naturally, plus a count of $clog2(DEPTH)+1 bits.
  - Entries hold raw fields. Extraction is combinational on the head entry only.
- Reset: count=0, head=tail=0. Outputs at reset: cdb_valid_o=0, mem_ready_o=1. Entry contents are don't-care; cdb_data_o is driven from the head entry, and the bench checks it only when cdb_valid_o=1.
- Push: occurs when mem_valid_i && mem_ready_o && !flush_i. Write at tail, then tail+1.
- mem_ready_o = (count != DEPTH). It is not combinationally dependent on cdb_ready_i, so a full buffer accepts nothing even if the head is popping that cycle.
- Pop: occurs when cdb_valid_o && cdb_ready_i && !flush_i. Then head+1.
- cdb_valid_o = (count != 0). It may not drop while cdb_ready_i=0, and the head fields stay stable until popped.
- Latency: a response pushed in cycle N is visible on the CDB in cycle N+1 at the earliest. There is no fall-through.
- Simultaneous push and pop with count between 1 and DEPTH-1: count unchanged, both pointers advance.
- Flush: on the next edge count=0 and head=tail. A push in the flush cycle is dropped, and any pop in that cycle is ignored.
- Extraction:
  - Word select uses off[2], halfword select uses off[1], byte select uses off[0].
  - LS_BYTE/LS_HALFWORD/LS_WORD are sign-extended to XLEN.
  - The _U variants are zero-padded.
  - LS_DOUBLEWORD passes the line unchanged.
  - Any other type passes the line unchanged.
- Misalignment:
  - LS_HALFWORD(_U) is misaligned when off[0]=1.
  - LS_WORD(_U) is misaligned when off[1:0]!=0.
  - LS_DOUBLEWORD is misaligned when off!=0.
- Exception priority:
  - mem_except_i: code E_LD_ACCESS_FAULT (5).
  - Otherwise, misaligned: code E_LD_ADDR_MISALIGNED (4).
  - When an exception is raised, cdb_data_o=0 and cdb_except_raised_o=1.
  - With no exception, cdb_except_raised_o=0 and cdb_except_code_o=0.
- Order: results leave strictly in push order.
- Assertions (non-synthesis): push while full, and pop while empty, never occur.

Decomposition:
- expipe_pkg gets:
  - lrb_entry_t struct: type, byte_off, line, rob_idx, except.
  - Constants E_LD_ADDR_MISALIGNED=4 and E_LD_ACCESS_FAULT=5.
- ldst_type_t is reused from expipe_pkg; XLEN comes from len5_pkg.
- Sub-module: the existing byte_selector is instantiated on the head entry for extraction and extension. Alignment check and exception muxing stay local.

Test Plan:
- Line 0x8877665544332211 with cdb_ready_i=1:
  - LS_BYTE off 7 -> data 0xFFFFFFFFFFFFFF88.
  - LS_BYTE_U off 7 -> 0x88.
  - LS_HALFWORD off 6 -> 0xFFFFFFFFFFFF8877.
  - LS_WORD off 4 -> 0xFFFFFFFF88776655.
  - LS_WORD_U off 0 -> 0x44332211.
  - Each result appears one cycle after its push.
- Misaligned and error cases:
  - LS_WORD off 2, rob_idx 3 -> cdb_valid_o=1, rob_idx 3, except_raised 1, code 4, data 0.
  - Same with mem_except_i=1 -> code 5.
- Back-pressure: push 4 responses (rob 0..3) with cdb_ready_i=0 -> mem_ready_o=0 after the 4th. Head holds rob 0 stable for 10 cycles. Releasing ready pops 0,1,2,3 on consecutive cycles.
- Streaming: continuous push with cdb_ready_i=1 -> count stays 1, one result per cycle, no bubble, pointers wrap past DEPTH-1 correctly.
- Flush: 3 entries held plus mem_valid_i=1 and flush_i=1 in the same cycle -> next cycle cdb_valid_o=0, mem_ready_o=1, flushed push absent.
- Reset: assert rst_n_i=0 asynchronously with 2 entries held -> cdb_valid_o falls without waiting for a clock edge. After release, the first new push appears normally.
